// File: rtl/gfsk_burst_modulator.sv
// GFSK modulation front end: bit stream -> repeat-upsample -> symmetric Gaussian FIR -> offset/saturate.
// Bursts frame themselves: the delay line is cleared on the first bit and the filter tail is flushed after the last.
module gfsk_burst_modulator #(
   parameter int GAUSS_FILTER_BIT_WIDTH = 6,
   parameter int NUM_TAP_GAUSS_FILTER   = 17,
   parameter int FMOD_BIT_WIDTH         = 8,
   parameter int TAP_INDEX_BIT_WIDTH    = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [1:0]                        sps_sel,
   input  logic [FMOD_BIT_WIDTH-1:0]         freq_offset,
   input  logic                              tap_we,
   input  logic [TAP_INDEX_BIT_WIDTH-1:0]    tap_index,
   input  logic [GAUSS_FILTER_BIT_WIDTH-1:0] tap_value,
   input  logic                              phy_bit,
   input  logic                              bit_valid,
   input  logic                              bit_valid_last,
   output logic                              bit_ready,
   output logic [FMOD_BIT_WIDTH-1:0]         fmod,
   output logic                              fmod_valid,
   output logic                              fmod_valid_last,
   output logic                              busy
);
   localparam int G     = GAUSS_FILTER_BIT_WIDTH;
   localparam int N     = NUM_TAP_GAUSS_FILTER;
   localparam int F     = FMOD_BIT_WIDTH;
   localparam int TIW   = TAP_INDEX_BIT_WIDTH;
   localparam int H     = (N - 1) / 2;
   localparam int ACC_W = G + $clog2(N) + 1;
   localparam int SUM_W = ((ACC_W > F) ? ACC_W : F) + 1;
   localparam int CNT_W = ($clog2(N) > 4) ? $clog2(N) : 4;

   localparam logic [CNT_W-1:0]        FLUSH_END = CNT_W'(N - 2);
   localparam logic signed [SUM_W-1:0] SAT_HI    = SUM_W'((2 ** (F - 1)) - 1);
   localparam logic signed [SUM_W-1:0] SAT_LO    = SUM_W'(-(2 ** (F - 1)));

   // Delay-line symbols are two's-complement -1/0/+1 so the filter is pure add/subtract/skip.
   localparam logic [1:0] SYM_ZERO = 2'b00;
   localparam logic [1:0] SYM_POS  = 2'b01;
   localparam logic [1:0] SYM_NEG  = 2'b11;

   typedef enum logic [1:0] {IDLE, RUN, WAIT, FLUSH} state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [CNT_W-1:0]        sps_m1_q, sps_m1_d;
   logic [CNT_W-1:0]        sps_decode;
   logic signed [F-1:0]     offset_q, offset_d;
   logic                    sym_q, sym_d;
   logic                    last_q, last_d;
   logic                    busy_q, busy_d;
   logic                    ready_q, ready_d;
   logic                    push_q, push_d;
   logic                    push_last_q, push_last_d;
   logic signed [F-1:0]     fmod_q, fmod_d;
   logic                    fmod_valid_q, fmod_valid_d;
   logic                    fmod_last_q, fmod_last_d;
   logic signed [G-1:0]     taps_q [H+1];
   logic signed [G-1:0]     taps_d [H+1];
   logic [1:0]              dl_q [N];
   logic [1:0]              dl_d [N];

   logic [1:0]              push_sym;
   logic                    accept;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] tap_ext;
   logic signed [SUM_W-1:0] sum;
   logic signed [F-1:0]     sat_val;

   // Upper half of the filter mirrors the programmable lower half.
   always_comb begin
      acc     = '0;
      tap_ext = '0;
      for (int k = 0; k < N; k++) begin
         tap_ext = ACC_W'(taps_q[(k <= H) ? k : (N - 1 - k)]);
         if (dl_q[k] == SYM_POS) begin
            acc = acc + tap_ext;
         end else if (dl_q[k] == SYM_NEG) begin
            acc = acc - tap_ext;
         end
      end
      sum = SUM_W'(acc) + SUM_W'(offset_q);
      if (sum > SAT_HI) begin
         sat_val = {1'b0, {(F - 1){1'b1}}};
      end else if (sum < SAT_LO) begin
         sat_val = {1'b1, {(F - 1){1'b0}}};
      end else begin
         sat_val = sum[F-1:0];
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sps_m1_d    = sps_m1_q;
      offset_d    = offset_q;
      sym_d       = sym_q;
      last_d      = last_q;
      busy_d      = busy_q;
      taps_d      = taps_q;
      dl_d        = dl_q;
      push_d      = 1'b0;
      push_sym    = SYM_ZERO;
      push_last_d = 1'b0;
      ready_d     = 1'b0;
      accept      = bit_ready && bit_valid;

      unique case (sps_sel)
         2'd0:    sps_decode = CNT_W'(1);
         2'd1:    sps_decode = CNT_W'(3);
         2'd2:    sps_decode = CNT_W'(7);
         default: sps_decode = CNT_W'(15);
      endcase

      // Out-of-range indices match no register, so such writes drop out naturally.
      if (state_q == IDLE && !busy_q && tap_we) begin
         for (int i = 0; i <= H; i++) begin
            if (tap_index == TIW'(i)) begin
               taps_d[i] = tap_value;
            end
         end
      end

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d  = RUN;
               cnt_d    = '0;
               sps_m1_d = sps_decode;
               offset_d = freq_offset;
               sym_d    = phy_bit;
               last_d   = bit_valid_last;
               busy_d   = 1'b1;
               for (int k = 0; k < N; k++) begin
                  dl_d[k] = SYM_ZERO;
               end
            end else if (fmod_last_q) begin
               busy_d = 1'b0;
            end
         end
         RUN: begin
            push_d   = 1'b1;
            push_sym = sym_q ? SYM_POS : SYM_NEG;
            if (cnt_q == sps_m1_q) begin
               cnt_d = '0;
               if (last_q) begin
                  state_d = FLUSH;
               end else if (accept) begin
                  sym_d  = phy_bit;
                  last_d = bit_valid_last;
               end else begin
                  state_d = WAIT;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WAIT: begin
            if (accept) begin
               state_d = RUN;
               cnt_d   = '0;
               sym_d   = phy_bit;
               last_d  = bit_valid_last;
            end
         end
         FLUSH: begin
            push_d = 1'b1;
            if (cnt_q == FLUSH_END) begin
               push_last_d = 1'b1;
               state_d     = IDLE;
               cnt_d       = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (push_d) begin
         dl_d[0] = push_sym;
         for (int k = 1; k < N; k++) begin
            dl_d[k] = dl_q[k-1];
         end
      end

      unique case (state_d)
         IDLE, WAIT: ready_d = 1'b1;
         RUN:        ready_d = (cnt_d == sps_m1_d) && !last_d;
         default:    ready_d = 1'b0;
      endcase

      fmod_valid_d = push_q;
      fmod_last_d  = push_last_q;
      fmod_d       = push_q ? sat_val : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         sps_m1_q     <= '0;
         offset_q     <= '0;
         sym_q        <= 1'b0;
         last_q       <= 1'b0;
         busy_q       <= 1'b0;
         ready_q      <= 1'b1;
         push_q       <= 1'b0;
         push_last_q  <= 1'b0;
         fmod_q       <= '0;
         fmod_valid_q <= 1'b0;
         fmod_last_q  <= 1'b0;
         taps_q       <= '{default: '0};
         dl_q         <= '{default: SYM_ZERO};
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sps_m1_q     <= sps_m1_d;
         offset_q     <= offset_d;
         sym_q        <= sym_d;
         last_q       <= last_d;
         busy_q       <= busy_d;
         ready_q      <= ready_d;
         push_q       <= push_d;
         push_last_q  <= push_last_d;
         fmod_q       <= fmod_d;
         fmod_valid_q <= fmod_valid_d;
         fmod_last_q  <= fmod_last_d;
         taps_q       <= taps_d;
         dl_q         <= dl_d;
      end
   end

   assign bit_ready       = rst && ready_q;
   assign fmod            = fmod_q;
   assign fmod_valid      = fmod_valid_q;
   assign fmod_valid_last = fmod_last_q;
   assign busy            = busy_q;

endmodule

// File: tb/tb_gfsk_burst_modulator.sv
// Randomized bench for gfsk_burst_modulator: each burst's expected fmod stream comes from a direct
// convolution of the upsampled +/-1 sequence with the full mirrored tap set, plus offset and clamp.
module tb_gfsk_burst_modulator;
   localparam int G    = 6;
   localparam int N    = 17;
   localparam int F    = 8;
   localparam int TIW  = 4;
   localparam int H    = (N - 1) / 2;
   localparam int MAXB = 32;
   localparam int MODE_NORMAL = 0;
   localparam int MODE_CHANGE = 1;
   localparam int MODE_ABORT  = 2;

   logic           clk;
   logic           rst;
   logic [1:0]     sps_sel;
   logic [F-1:0]   freq_offset;
   logic           tap_we;
   logic [TIW-1:0] tap_index;
   logic [G-1:0]   tap_value;
   logic           phy_bit;
   logic           bit_valid;
   logic           bit_valid_last;
   logic           bit_ready;
   logic [F-1:0]   fmod;
   logic           fmod_valid;
   logic           fmod_valid_last;
   logic           busy;

   int vectors;
   int miscompares;
   int tap_model [H+1];
   int bits_arr [MAXB];
   int gaps_arr [MAXB];
   int exp_q [$];
   int mon_idx;
   int gap_cycles;
   bit started;
   bit last_seen;
   bit busy_check;

   gfsk_burst_modulator #(
      .GAUSS_FILTER_BIT_WIDTH (G),
      .NUM_TAP_GAUSS_FILTER   (N),
      .FMOD_BIT_WIDTH         (F),
      .TAP_INDEX_BIT_WIDTH    (TIW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .sps_sel         (sps_sel),
      .freq_offset     (freq_offset),
      .tap_we          (tap_we),
      .tap_index       (tap_index),
      .tap_value       (tap_value),
      .phy_bit         (phy_bit),
      .bit_valid       (bit_valid),
      .bit_valid_last  (bit_valid_last),
      .bit_ready       (bit_ready),
      .fmod            (fmod),
      .fmod_valid      (fmod_valid),
      .fmod_valid_last (fmod_valid_last),
      .busy            (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      vectors++;
      if (observed != expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
      end
   endtask

   function automatic int clampF(input int v);
      if (v > (2 ** (F - 1)) - 1) return (2 ** (F - 1)) - 1;
      if (v < -(2 ** (F - 1))) return -(2 ** (F - 1));
      return v;
   endfunction

   function automatic int fullTap(input int k);
      return (k <= H) ? tap_model[k] : tap_model[N - 1 - k];
   endfunction

   // Expected stream: convolve the repeated symbols followed by N-1 zeros, starting from an empty filter.
   task automatic buildModel(input int nbits, input int sps, input int offset);
      int u [$];
      int y;
      exp_q.delete();
      for (int i = 0; i < nbits; i++) begin
         for (int r = 0; r < sps; r++) u.push_back((bits_arr[i] != 0) ? 1 : -1);
      end
      for (int r = 0; r < N - 1; r++) u.push_back(0);
      for (int n = 0; n < u.size(); n++) begin
         y = 0;
         for (int k = 0; k < N; k++) begin
            if (n - k >= 0) y += fullTap(k) * u[n - k];
         end
         exp_q.push_back(clampF(y + offset));
      end
   endtask

   task automatic monitorOutput();
      int e;
      if (busy_check) begin
         checkOutput("busy_after_last", int'(busy), 0);
         busy_check = 1'b0;
      end
      if (fmod_valid_last && !fmod_valid) checkOutput("last_without_valid", 1, 0);
      if (fmod_valid) begin
         started = 1'b1;
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_sample", 1, 0);
         end else begin
            e = exp_q.pop_front();
            checkOutput($sformatf("fmod[%0d]", mon_idx), int'($signed(fmod)), e);
            checkOutput($sformatf("last[%0d]", mon_idx), int'(fmod_valid_last), int'(exp_q.size() == 0));
            mon_idx++;
            if (exp_q.size() == 0) begin
               checkOutput("busy_at_last", int'(busy), 1);
               last_seen  = 1'b1;
               busy_check = 1'b1;
            end
         end
      end else if (started && !last_seen) begin
         gap_cycles++;
      end
   endtask

   task automatic step();
      @(negedge clk);
      monitorOutput();
   endtask

   task automatic programTaps();
      for (int k = 0; k <= H; k++) begin
         step();
         tap_we    = 1'b1;
         tap_index = TIW'(k);
         tap_value = G'(tap_model[k]);
      end
      step();
      tap_index = TIW'(H + 1 + $urandom_range(0, (2 ** TIW) - H - 2));
      tap_value = G'($urandom);
      step();
      tap_we = 1'b0;
   endtask

   task automatic applyStimulus(input int nbits, input int sps_code, input int offset, input int mode);
      int sps;
      int i;
      int gap_rem;
      int cyc;
      int exp_gap;
      bit aborted;
      bit disturbed;
      sps = 2 << sps_code;
      buildModel(nbits, sps, offset);
      exp_gap = 0;
      for (int b = 1; b < nbits; b++) exp_gap += gaps_arr[b];
      started    = 1'b0;
      last_seen  = 1'b0;
      gap_cycles = 0;
      mon_idx    = 0;
      aborted    = 1'b0;
      disturbed  = 1'b0;
      i          = 0;
      gap_rem    = 0;
      cyc        = 0;
      sps_sel     = 2'(sps_code);
      freq_offset = F'(offset);
      while (!last_seen && !aborted && cyc < 3000) begin
         step();
         cyc++;
         tap_we = 1'b0;
         if (mode == MODE_ABORT && mon_idx >= 3) begin
            rst       = 1'b0;
            bit_valid = 1'b0;
            aborted   = 1'b1;
            exp_q.delete();
         end else begin
            if (mode == MODE_CHANGE && i >= 1 && !disturbed) begin
               sps_sel     = 2'd3;
               freq_offset = F'($urandom);
               tap_we      = 1'b1;
               tap_index   = TIW'($urandom_range(0, H));
               tap_value   = G'($urandom);
               disturbed   = 1'b1;
            end
            if (i < nbits) begin
               if (gap_rem > 0) begin
                  bit_valid      = 1'b0;
                  bit_valid_last = 1'($urandom_range(0, 1));
                  if (bit_ready) gap_rem--;
               end else begin
                  bit_valid      = 1'b1;
                  phy_bit        = 1'(bits_arr[i]);
                  bit_valid_last = (i == nbits - 1);
                  if (bit_ready) begin
                     i++;
                     if (i < nbits) gap_rem = gaps_arr[i];
                  end
               end
            end else begin
               bit_valid      = 1'b0;
               bit_valid_last = 1'b0;
            end
         end
      end
      if (aborted) begin
         step();
         checkOutput("abort_fmod_valid", int'(fmod_valid), 0);
         checkOutput("abort_busy", int'(busy), 0);
         checkOutput("abort_fmod", int'($signed(fmod)), 0);
         checkOutput("ready_in_reset", int'(bit_ready), 0);
         rst = 1'b1;
         repeat (24) step();
      end else begin
         checkOutput("burst_complete", int'(last_seen), 1);
         checkOutput("samples_left", exp_q.size(), 0);
         checkOutput("sample_count", mon_idx, nbits * sps + N - 1);
         checkOutput("gap_cycles", gap_cycles, exp_gap);
         step();
         step();
      end
   endtask

   task automatic clearGaps();
      for (int b = 0; b < MAXB; b++) gaps_arr[b] = 0;
   endtask

   task automatic randomBits(input int nbits);
      for (int b = 0; b < nbits; b++) bits_arr[b] = $urandom_range(0, 1);
   endtask

   initial begin
      vectors        = 0;
      miscompares    = 0;
      rst            = 1'b0;
      sps_sel        = '0;
      freq_offset    = '0;
      tap_we         = 1'b0;
      tap_index      = '0;
      tap_value      = '0;
      phy_bit        = 1'b0;
      bit_valid      = 1'b0;
      bit_valid_last = 1'b0;
      busy_check     = 1'b0;
      started        = 1'b0;
      last_seen      = 1'b0;
      mon_idx        = 0;
      gap_cycles     = 0;
      clearGaps();

      repeat (3) step();
      checkOutput("reset_fmod", int'($signed(fmod)), 0);
      checkOutput("reset_fmod_valid", int'(fmod_valid), 0);
      checkOutput("reset_fmod_last", int'(fmod_valid_last), 0);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_ready", int'(bit_ready), 0);
      rst = 1'b1;
      step();
      checkOutput("idle_ready", int'(bit_ready), 1);
      checkOutput("idle_busy", int'(busy), 0);

      $display("[TB] centre tap impulse");
      for (int k = 0; k <= H; k++) tap_model[k] = 0;
      tap_model[H] = 16;
      programTaps();
      bits_arr[0] = 1;
      applyStimulus(1, 2, 0, MODE_NORMAL);

      $display("[TB] offset saturation");
      bits_arr[0] = 1;
      bits_arr[1] = 0;
      applyStimulus(2, 2, 120, MODE_NORMAL);
      applyStimulus(2, 2, -120, MODE_NORMAL);

      $display("[TB] ramp taps, continuous stream");
      for (int k = 0; k <= H; k++) tap_model[k] = k + 1;
      programTaps();
      for (int b = 0; b < 10; b++) bits_arr[b] = b % 2;
      applyStimulus(10, 0, 0, MODE_NORMAL);

      $display("[TB] underrun gap");
      randomBits(8);
      gaps_arr[4] = 5;
      applyStimulus(8, 1, int'($urandom_range(0, 60)) - 30, MODE_NORMAL);
      clearGaps();

      $display("[TB] mid-burst sps/offset change and tap write");
      randomBits(6);
      applyStimulus(6, 0, int'($urandom_range(0, 80)) - 40, MODE_CHANGE);
      randomBits(4);
      applyStimulus(4, 1, 0, MODE_NORMAL);

      $display("[TB] mid-burst reset");
      randomBits(6);
      applyStimulus(6, 1, 10, MODE_ABORT);
      programTaps();
      randomBits(5);
      applyStimulus(5, 0, -7, MODE_NORMAL);

      $display("[TB] random bursts");
      for (int r = 0; r < 5; r++) begin
         int nb;
         for (int k = 0; k <= H; k++) tap_model[k] = int'($urandom_range(0, 63)) - 32;
         programTaps();
         nb = $urandom_range(1, 8);
         randomBits(nb);
         for (int b = 1; b < nb; b++) gaps_arr[b] = $urandom_range(0, 3);
         applyStimulus(nb, $urandom_range(0, 3), int'($urandom_range(0, 255)) - 128, MODE_NORMAL);
         clearGaps();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
